cache_meta_array: RTL and testbench
===================================

// Module: cache_meta_array
// PURPOSE
//   Set-associative metadata store (valid/dirty/tag per way) for the L1 caches.
//   Generalises the single-way meta RAM: parametrised sets/ways/tag width, per-way
//   write mask, registered tag compare (hit/hit_way), victim selection, and a
//   hardware flush that clears valid/dirty after reset or on request.
//   Sits beside the data array and is driven by the cache control FSM.
// PARAMETERS
//   SETS   64  number of sets, power of two >= 2
//   WAYS   4   associativity, power of two >= 1
//   TAG_W  23  tag width in bits
//   IDX_W  $clog2(SETS), derived set-index width
// PORTS
//   clock      in   1            single clock, all state on posedge
//   reset      in   1            synchronous, active-high
//   en         in   1            request valid
//   wr         in   1            1 = write, 0 = read/lookup
//   addr       in   IDX_W        set index
//   cmp_tag    in   TAG_W        lookup tag, sampled with a read
//   wway_mask  in   WAYS         ways written on a write (one-hot or multi)
//   wvalid     in   1            valid bit written to masked ways
//   wdirty     in   1            dirty bit written to masked ways
//   wtag       in   TAG_W        tag written to masked ways
//   flush_req  in   1            start full invalidate (pulse)
//   ready      out  1            1 = IDLE, requests accepted
//   rvalid     out  WAYS         per-way valid of last read
//   rdirty     out  WAYS         per-way dirty of last read
//   rtag       out  WAYS*TAG_W   per-way tag, way w at [w*TAG_W +: TAG_W]
//   hit        out  1            any valid way tag == sampled cmp_tag
//   hit_way    out  WAYS         one-hot hit way (lowest index if multiple)
//   victim_way out  WAYS         one-hot replacement candidate
// BEHAVIOUR
//   - FSM: FLUSH, IDLE. reset -> FLUSH, flush_idx=0. FLUSH: clears valid and dirty
//     of all ways of set flush_idx each cycle, flush_idx++; at SETS-1 -> IDLE.
//     Flush takes exactly SETS cycles; ready=1 the cycle after the last clear.
//   - IDLE & flush_req -> FLUSH next cycle (flush_idx=0); flush_req wins over a
//     same-cycle en (request dropped). flush_req in FLUSH ignored (no restart).
//   - Requests accepted only when en & ready; en while !ready is ignored, the
//     controller must hold and retry. Tags are not cleared by flush.
//   - Read: accepted at cycle t -> rvalid/rdirty/rtag/hit/hit_way/victim_way
//     valid at t+1 and held until the next accepted read (writes do not disturb).
//   - hit_way[w] = rvalid[w] & (rtag[w]==cmp_tag captured at t); hit = |hit_way.
//   - victim_way: lowest-index invalid way of the read set; if all valid,
//     one-hot of rr_ptr (global round-robin, WAYS-wrap, reset 0).
//   - Write: accepted at t updates masked ways at posedge t; read of the same set
//     at t+1 returns new values. wway_mask=0 -> no state change.
//   - rr_ptr advances by 1 (mod WAYS) on each accepted write with wvalid=1 and
//     wway_mask!=0; wraps WAYS-1 -> 0. Not changed by flush.
//   - Reset values: ready=0, rvalid=0, rdirty=0, rtag=0, hit=0, hit_way=0,
//     victim_way=0 (output regs), rr_ptr=0. Reset asserted mid-flush or mid-
//     operation restarts flush from set 0; pending read result is zeroed.
//   - WAYS=1: victim_way=1'b1 whenever a read has completed; rr_ptr constant 0.
// STRUCTURE
//   - Shared package cache_pkg: meta_entry_t {valid, dirty, tag}, flush state
//     enum {MS_FLUSH, MS_IDLE}, default SETS/WAYS/TAG_W constants.
//   - Sub-module cache_meta_way: one way's storage (tag RAM + valid/dirty
//     vectors, sync read, write enable, per-set clear port); top instantiates
//     WAYS copies plus FSM, compare, victim and rr_ptr logic.
// TESTING
//   - Reset 1 cycle -> ready=0 for exactly 64 cycles (SETS=64), then 1; read any
//     set -> rvalid=0000, hit=0, victim_way=0001.
//   - Write set 5 mask 0100 tag 0x12345 v=1 d=1; read set 5 cmp_tag 0x12345 ->
//     next cycle hit=1, hit_way=0100, rdirty=0100, victim_way=0001.
//   - Fill set 9 ways 0..3 valid (4 writes) -> rr_ptr=0; read set 9 -> victim_way
//     0001; one more valid write -> next read victim_way=0010.
//   - Write set 3 valid, pulse flush_req -> ready low 64 cycles, en ignored
//     throughout; read set 3 afterwards -> rvalid=0000, hit=0.
//   - Assert reset at flush cycle 20 -> flush restarts, ready rises 64 cycles
//     after reset release; all read outputs 0 during reset.
//   - Same tag valid in ways 1 and 3 -> hit_way=0010; write with mask 0000 ->
//     no change on re-read.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared definitions for the L1 cache metadata store.
//   - Default geometry constants (sets, ways, tag width).
//   - meta_entry_t: the per-way metadata record {valid, dirty, tag}.
//   - meta_state_e: flush sequencer state.
package cache_pkg;

  localparam int DEF_SETS  = 64;
  localparam int DEF_WAYS  = 4;
  localparam int DEF_TAG_W = 23;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
  } meta_entry_t;

  typedef enum logic {
    MS_FLUSH = 1'b0,
    MS_IDLE  = 1'b1
  } meta_state_e;

endpackage

// File: rtl/cache_meta_way.sv
// One way of the metadata array: tag RAM plus per-set valid/dirty bit vectors.
// Ports:
//   clock, reset          clock and synchronous active-high reset (read regs only)
//   rd_en, addr           synchronous read of set addr, result next cycle
//   wr_en, wvalid, wdirty, wtag   write of set addr
//   clr_en, clr_idx       clear valid/dirty of set clr_idx (flush), tag kept
//   rd_valid, rd_dirty, rd_tag    registered read result, held between reads
module cache_meta_way
  import cache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = DEF_TAG_W,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] addr,
  input  logic             wvalid,
  input  logic             wdirty,
  input  logic [TAG_W-1:0] wtag,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  output logic             rd_valid,
  output logic             rd_dirty,
  output logic [TAG_W-1:0] rd_tag
);

  logic [TAG_W-1:0] tag_mem [SETS];
  logic [SETS-1:0]  valid_vec;
  logic [SETS-1:0]  dirty_vec;

  // NOTE: storage arrays carry no reset; the flush sequence clears valid/dirty
  // set by set, and tags are don't-care while their valid bit is low.
  always_ff @(posedge clock) begin
    if (wr_en) tag_mem[addr] <= wtag;
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clr_en) begin
      valid_vec[clr_idx] <= 1'b0;
      dirty_vec[clr_idx] <= 1'b0;
    end else if (wr_en) begin
      valid_vec[addr] <= wvalid;
      dirty_vec[addr] <= wdirty;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
      rd_tag   <= '0;
    end else if (rd_en) begin
      rd_valid <= valid_vec[addr];
      rd_dirty <= dirty_vec[addr];
      rd_tag   <= tag_mem[addr];
    end
  end

endmodule

// File: rtl/cache_meta_array.sv
// Set-associative metadata store (valid/dirty/tag per way) for the L1 caches.
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   en, wr, addr        request valid, 1=write/0=read, set index
//   cmp_tag             lookup tag, captured with an accepted read
//   wway_mask, wvalid, wdirty, wtag   masked way write
//   flush_req           start full invalidate (ignored while flushing)
//   ready               high in IDLE, requests accepted only then
//   rvalid, rdirty, rtag   per-way result of the last read (way w at w*TAG_W)
//   hit, hit_way        tag compare of last read, lowest way wins
//   victim_way          lowest invalid way, else round-robin pointer
module cache_meta_array
  import cache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int WAYS  = DEF_WAYS,
  parameter int TAG_W = DEF_TAG_W,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  wr,
  input  logic [IDX_W-1:0]      addr,
  input  logic [TAG_W-1:0]      cmp_tag,
  input  logic [WAYS-1:0]       wway_mask,
  input  logic                  wvalid,
  input  logic                  wdirty,
  input  logic [TAG_W-1:0]      wtag,
  input  logic                  flush_req,
  output logic                  ready,
  output logic [WAYS-1:0]       rvalid,
  output logic [WAYS-1:0]       rdirty,
  output logic [WAYS*TAG_W-1:0] rtag,
  output logic                  hit,
  output logic [WAYS-1:0]       hit_way,
  output logic [WAYS-1:0]       victim_way
);

  localparam int RR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  meta_state_e      state_q, state_d;
  logic [IDX_W-1:0] flush_idx_q, flush_idx_d;
  logic             clr_en;
  logic             acc_rd, acc_wr;
  logic [RR_W-1:0]  rr_ptr, rr_q;
  logic [TAG_W-1:0] cmp_q;
  logic             rd_done;

  // A same-cycle flush_req wins over en, and nothing is accepted in reset.
  assign acc_rd = en & ready & ~flush_req & ~reset & ~wr;
  assign acc_wr = en & ready & ~flush_req & ~reset & wr;

  // Flush sequencer: state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= MS_FLUSH;
      flush_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_idx_q <= flush_idx_d;
    end
  end

  // Flush sequencer: next state.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    flush_idx_d = flush_idx_q;
    case (state_q)
      MS_FLUSH: begin
        flush_idx_d = flush_idx_q + IDX_W'(1);
        if (flush_idx_q == IDX_W'(SETS - 1)) state_d = MS_IDLE;
      end
      MS_IDLE: begin
        if (flush_req) begin
          state_d     = MS_FLUSH;
          flush_idx_d = '0;
        end
      end
      default: state_d = MS_FLUSH;
    endcase
  end

  // Flush sequencer: outputs.
  always_comb begin
    ready  = (state_q == MS_IDLE);
    clr_en = (state_q == MS_FLUSH);
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_meta_way #(
      .SETS (SETS),
      .TAG_W(TAG_W),
      .IDX_W(IDX_W)
    ) u_way (
      .clock   (clock),
      .reset   (reset),
      .rd_en   (acc_rd),
      .wr_en   (acc_wr & wway_mask[w]),
      .addr    (addr),
      .wvalid  (wvalid),
      .wdirty  (wdirty),
      .wtag    (wtag),
      .clr_en  (clr_en),
      .clr_idx (flush_idx_q),
      .rd_valid(rvalid[w]),
      .rd_dirty(rdirty[w]),
      .rd_tag  (rtag[w*TAG_W +: TAG_W])
    );
  end

  // Round-robin pointer plus the per-read context (compare tag, pointer
  // snapshot) so compare and victim outputs hold until the next read.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr  <= '0;
      rr_q    <= '0;
      cmp_q   <= '0;
      rd_done <= 1'b0;
    end else begin
      if (acc_wr && wvalid && (wway_mask != '0)) begin
        rr_ptr <= (WAYS > 1) ? rr_ptr + RR_W'(1) : '0;
      end
      if (acc_rd) begin
        rr_q    <= rr_ptr;
        cmp_q   <= cmp_tag;
        rd_done <= 1'b1;
      end
    end
  end

  always_comb begin
    hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (hit_way == '0 && rvalid[i] && (rtag[i*TAG_W +: TAG_W] == cmp_q)) begin
        hit_way[i] = 1'b1;
      end
    end
    hit = |hit_way;
  end

  always_comb begin
    victim_way = '0;
    if (rd_done) begin
      for (int i = 0; i < WAYS; i++) begin
        if (victim_way == '0 && !rvalid[i]) victim_way[i] = 1'b1;
      end
      if (victim_way == '0) victim_way[rr_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_meta_array.sv
module tb_cache_meta_array;

  localparam int SETS  = 64;
  localparam int WAYS  = 4;
  localparam int TAG_W = 23;
  localparam int IDX_W = 6;

  logic                  clock = 1'b0;
  logic                  reset = 1'b0;
  logic                  en = 1'b0;
  logic                  wr = 1'b0;
  logic [IDX_W-1:0]      addr = '0;
  logic [TAG_W-1:0]      cmp_tag = '0;
  logic [WAYS-1:0]       wway_mask = '0;
  logic                  wvalid = 1'b0;
  logic                  wdirty = 1'b0;
  logic [TAG_W-1:0]      wtag = '0;
  logic                  flush_req = 1'b0;
  logic                  ready;
  logic [WAYS-1:0]       rvalid;
  logic [WAYS-1:0]       rdirty;
  logic [WAYS*TAG_W-1:0] rtag;
  logic                  hit;
  logic [WAYS-1:0]       hit_way;
  logic [WAYS-1:0]       victim_way;

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  cache_meta_array #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .wr        (wr),
    .addr      (addr),
    .cmp_tag   (cmp_tag),
    .wway_mask (wway_mask),
    .wvalid    (wvalid),
    .wdirty    (wdirty),
    .wtag      (wtag),
    .flush_req (flush_req),
    .ready     (ready),
    .rvalid    (rvalid),
    .rdirty    (rdirty),
    .rtag      (rtag),
    .hit       (hit),
    .hit_way   (hit_way),
    .victim_way(victim_way)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [IDX_W-1:0] a, input logic [WAYS-1:0] m,
                          input logic v, input logic d, input logic [TAG_W-1:0] t);
    addr = a; wway_mask = m; wvalid = v; wdirty = d; wtag = t;
    en = 1'b1; wr = 1'b1;
    tick();
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic do_read(input logic [IDX_W-1:0] a, input logic [TAG_W-1:0] c);
    addr = a; cmp_tag = c; en = 1'b1; wr = 1'b0;
    tick();
    en = 1'b0;
  endtask

  // Counts cycles until ready rises; bounded so a stuck flush still ends.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (!ready && cnt < 200) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    reset = 1'b1;
    tick();
    total++; if (ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", ready); else passed++;
    total++; if (rvalid !== 4'b0000 || rdirty !== 4'b0000) $display("FAIL rst_rvd: got %b/%b want 0000/0000", rvalid, rdirty); else passed++;
    total++; if (rtag !== '0) $display("FAIL rst_rtag: got %h want 0", rtag); else passed++;
    total++; if (hit !== 1'b0 || hit_way !== 4'b0000 || victim_way !== 4'b0000)
      $display("FAIL rst_hv: got hit=%b hw=%b vw=%b want 0/0000/0000", hit, hit_way, victim_way); else passed++;
    reset = 1'b0;
    wait_ready(cnt);
    total++; if (cnt !== 64) $display("FAIL rst_flush_len: got %0d want 64", cnt); else passed++;
    do_read(6'd0, 23'h0);
    total++; if (rvalid !== 4'b0000 || hit !== 1'b0 || victim_way !== 4'b0001)
      $display("FAIL rst_read: got rv=%b hit=%b vw=%b want 0000/0/0001", rvalid, hit, victim_way); else passed++;
  endtask

  // rr_ptr is 0 here; four valid writes bring it back to 0, the fifth to 1.
  task automatic test_victim();
    for (int w = 0; w < 4; w++) do_write(6'd9, 4'b0001 << w, 1'b1, 1'b0, 23'h100 + 23'(w));
    do_read(6'd9, 23'h100);
    total++; if (rvalid !== 4'b1111 || victim_way !== 4'b0001)
      $display("FAIL vic_full0: got rv=%b vw=%b want 1111/0001", rvalid, victim_way); else passed++;
    total++; if (hit_way !== 4'b0001) $display("FAIL vic_hit0: got %b want 0001", hit_way); else passed++;
    do_write(6'd9, 4'b0001, 1'b1, 1'b0, 23'h100);
    total++; if (victim_way !== 4'b0001 || rvalid !== 4'b1111)
      $display("FAIL vic_hold: got vw=%b rv=%b want 0001/1111", victim_way, rvalid); else passed++;
    do_read(6'd9, 23'h103);
    total++; if (victim_way !== 4'b0010 || hit_way !== 4'b1000)
      $display("FAIL vic_rr1: got vw=%b hw=%b want 0010/1000", victim_way, hit_way); else passed++;
  endtask

  task automatic test_hit();
    do_write(6'd5, 4'b0100, 1'b1, 1'b1, 23'h12345);
    do_read(6'd5, 23'h12345);
    total++; if (hit !== 1'b1 || hit_way !== 4'b0100)
      $display("FAIL hit_basic: got hit=%b hw=%b want 1/0100", hit, hit_way); else passed++;
    total++; if (rvalid !== 4'b0100 || rdirty !== 4'b0100)
      $display("FAIL hit_vd: got rv=%b rd=%b want 0100/0100", rvalid, rdirty); else passed++;
    total++; if (rtag[2*TAG_W +: TAG_W] !== 23'h12345)
      $display("FAIL hit_tag: got %h want 12345", rtag[2*TAG_W +: TAG_W]); else passed++;
    total++; if (victim_way !== 4'b0001) $display("FAIL hit_vic: got %b want 0001", victim_way); else passed++;
  endtask

  task automatic test_flush();
    int cnt;
    do_write(6'd3, 4'b0001, 1'b1, 1'b1, 23'h3ABC);
    // Same-cycle en is dropped; en stays high through the flush and must be ignored.
    addr = 6'd3; wway_mask = 4'b1111; wvalid = 1'b1; wdirty = 1'b1; wtag = 23'h7777;
    en = 1'b1; wr = 1'b1; flush_req = 1'b1;
    tick();
    cnt = 0;
    while (!ready && cnt < 200) begin
      flush_req = (cnt == 10);
      tick();
      cnt++;
    end
    en = 1'b0; wr = 1'b0; flush_req = 1'b0;
    total++; if (cnt !== 64) $display("FAIL flush_len: got %0d want 64", cnt); else passed++;
    do_read(6'd3, 23'h3ABC);
    total++; if (rvalid !== 4'b0000 || rdirty !== 4'b0000 || hit !== 1'b0)
      $display("FAIL flush_clear: got rv=%b rd=%b hit=%b want 0000/0000/0", rvalid, rdirty, hit); else passed++;
    total++; if (rtag[0 +: TAG_W] !== 23'h3ABC)
      $display("FAIL flush_tag_kept: got %h want 3abc", rtag[0 +: TAG_W]); else passed++;
  endtask

  task automatic test_reset_mid_flush();
    int cnt;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    reset = 1'b1;
    tick();
    total++; if (ready !== 1'b0 || rtag !== '0 || victim_way !== 4'b0000 || rvalid !== 4'b0000)
      $display("FAIL midrst_out: got rdy=%b rtag=%h vw=%b rv=%b want all 0", ready, rtag, victim_way, rvalid); else passed++;
    reset = 1'b0;
    wait_ready(cnt);
    total++; if (cnt !== 64) $display("FAIL midrst_flush_len: got %0d want 64", cnt); else passed++;
  endtask

  task automatic test_multi_hit();
    do_write(6'd7, 4'b1010, 1'b1, 1'b0, 23'h0ABCD);
    do_read(6'd7, 23'h0ABCD);
    total++; if (hit_way !== 4'b0010 || hit !== 1'b1 || rvalid !== 4'b1010)
      $display("FAIL multi_hit: got hw=%b hit=%b rv=%b want 0010/1/1010", hit_way, hit, rvalid); else passed++;
    do_write(6'd7, 4'b0000, 1'b0, 1'b1, 23'h11111);
    do_read(6'd7, 23'h0ABCD);
    total++; if (rvalid !== 4'b1010 || rdirty !== 4'b0000 || rtag[1*TAG_W +: TAG_W] !== 23'h0ABCD)
      $display("FAIL zero_mask: got rv=%b rd=%b t1=%h want 1010/0000/0abcd", rvalid, rdirty, rtag[1*TAG_W +: TAG_W]); else passed++;
    total++; if (hit_way !== 4'b0010 || victim_way !== 4'b0001)
      $display("FAIL zero_mask_hv: got hw=%b vw=%b want 0010/0001", hit_way, victim_way); else passed++;
    do_read(6'd7, 23'h0ABCE);
    total++; if (hit !== 1'b0 || hit_way !== 4'b0000)
      $display("FAIL miss: got hit=%b hw=%b want 0/0000", hit, hit_way); else passed++;
  endtask

  initial begin
    test_reset();
    test_victim();
    test_hit();
    test_flush();
    test_reset_mid_flush();
    test_multi_hit();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
